// File: rtl/bishift_datarev_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bishift_datarev_pipe_if                                                   |
// | Streaming handshake and payload bundle for the bidirectional shifter.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface bishift_datarev_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data;
    logic             left;
    logic [1:0]       mode;
    logic [SHW-1:0]   sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_zero;

    modport master (
        output in_valid, data, left, mode, sel, out_ready,
        input  in_ready, out_valid, out, out_zero
    );

    modport slave (
        input  in_valid, data, left, mode, sel, out_ready,
        output in_ready, out_valid, out, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/bishift_datarev_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bishift_datarev_pipe                                                      |
// | Pipelined WIDTH-bit shift/rotate built from bit reversal around a single |
// | right-shift network. BISHIFT_PIPE_MID_EN adds a mid-network stage.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module bishift_datarev_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bishift_datarev_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MID = (SHW + 1) / 2;

    function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        for (int i = 0; i < WIDTH; i++) y[i] = x[WIDTH-1-i];
        return y;
    endfunction

    // One right-shift layer; rotate wraps the dropped bits, otherwise fill.
    function automatic logic [WIDTH-1:0] f_layer(input logic [WIDTH-1:0] x,
                                                 input logic en, input logic rot,
                                                 input logic fill, input int amt);
        logic [WIDTH-1:0] keep;
        keep = {WIDTH{1'b1}} >> amt;
        if (!en) return x;
        if (rot) return (x >> amt) | (x << (WIDTH - amt));
        return (x >> amt) | (fill ? ~keep : '0);
    endfunction

    logic             w_adv;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s1_left;
    logic [1:0]       r_s1_mode;
    logic [SHW-1:0]   r_s1_sel;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_out_zero;

    assign w_adv        = bus.out_ready | ~r_out_valid;
    assign bus.in_ready = w_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_left  <= 1'b0;
            r_s1_mode  <= 2'b00;
            r_s1_sel   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            r_s1_data  <= bus.data;
            r_s1_left  <= bus.left;
            r_s1_mode  <= bus.mode;
            r_s1_sel   <= bus.sel;
        end
    end

    logic                      w_rot_a;
    logic                      w_fill_a;
    logic [MID:0][WIDTH-1:0]   w_lay_a;

    // Arithmetic fill only applies to right shifts; left shifts are logical.
    assign w_rot_a    = (r_s1_mode == 2'b10);
    assign w_fill_a   = r_s1_data[WIDTH-1] & (r_s1_mode == 2'b01) & ~r_s1_left;
    assign w_lay_a[0] = r_s1_left ? f_rev(r_s1_data) : r_s1_data;

    for (genvar k = 0; k < MID; k++) begin : g_layer_a
        assign w_lay_a[k+1] = f_layer(w_lay_a[k], r_s1_sel[k], w_rot_a, w_fill_a, 1 << k);
    end

    logic [WIDTH-1:0]   w_word_b;
    logic [SHW-MID-1:0] w_sel_hi;
    logic               w_rot_b;
    logic               w_fill_b;
    logic               w_left_b;
    logic               w_valid_b;

`ifdef BISHIFT_PIPE_MID_EN
    logic               r_s2_valid;
    logic [WIDTH-1:0]   r_s2_word;
    logic [SHW-MID-1:0] r_s2_sel_hi;
    logic               r_s2_rot;
    logic               r_s2_fill;
    logic               r_s2_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_word   <= '0;
            r_s2_sel_hi <= '0;
            r_s2_rot    <= 1'b0;
            r_s2_fill   <= 1'b0;
            r_s2_left   <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_word   <= w_lay_a[MID];
            r_s2_sel_hi <= r_s1_sel[SHW-1:MID];
            r_s2_rot    <= w_rot_a;
            r_s2_fill   <= w_fill_a;
            r_s2_left   <= r_s1_left;
        end
    end

    assign w_word_b  = r_s2_word;
    assign w_sel_hi  = r_s2_sel_hi;
    assign w_rot_b   = r_s2_rot;
    assign w_fill_b  = r_s2_fill;
    assign w_left_b  = r_s2_left;
    assign w_valid_b = r_s2_valid;
`else
    assign w_word_b  = w_lay_a[MID];
    assign w_sel_hi  = r_s1_sel[SHW-1:MID];
    assign w_rot_b   = w_rot_a;
    assign w_fill_b  = w_fill_a;
    assign w_left_b  = r_s1_left;
    assign w_valid_b = r_s1_valid;
`endif

    logic [SHW-MID:0][WIDTH-1:0] w_lay_b;
    logic [WIDTH-1:0]            w_res;

    assign w_lay_b[0] = w_word_b;

    for (genvar j = 0; j < SHW - MID; j++) begin : g_layer_b
        assign w_lay_b[j+1] = f_layer(w_lay_b[j], w_sel_hi[j], w_rot_b, w_fill_b, 1 << (MID + j));
    end

    assign w_res = w_left_b ? f_rev(w_lay_b[SHW-MID]) : w_lay_b[SHW-MID];

    // Result payload only moves with a real word so the output stays quiet across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_zero  <= 1'b1;
        end else if (w_adv) begin
            r_out_valid <= w_valid_b;
            if (w_valid_b) begin
                r_out      <= w_res;
                r_out_zero <= (w_res == '0);
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.out_zero  = r_out_zero;
endmodule
`default_nettype wire

// File: tb/tb_bishift_datarev_pipe.sv
`default_nettype none
// Self-checking bench for bishift_datarev_pipe at WIDTH=8: vector table,
// streaming, backpressure, async reset mid-stall and random traffic.
module tb_bishift_datarev_pipe;
    localparam int W = 8;
`ifdef BISHIFT_PIPE_MID_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int NV = 14;

    typedef struct {
        logic [7:0] data;
        logic       left;
        logic [1:0] mode;
        logic [2:0] sel;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bishift_datarev_pipe_if #(.WIDTH(W)) bus ();
    bishift_datarev_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] q[$];
    vec_t       tbl[NV];

    task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic l,
                                             input logic [1:0] m, input int s);
        logic [7:0] r;
        if (m == 2'b10) begin
            if (s == 0) r = d;
            else if (l) r = (d << s) | (d >> (W - s));
            else        r = (d >> s) | (d << (W - s));
        end else if (m == 2'b01 && !l) begin
            r = $signed(d) >>> s;
        end else begin
            r = l ? (d << s) : (d >> s);
        end
        return r;
    endfunction

    task automatic send(input logic [7:0] d, input logic l, input logic [1:0] m,
                        input logic [2:0] s, input logic [7:0] e);
        int waits = 0;
        bus.in_valid = 1'b1;
        bus.data = d; bus.left = l; bus.mode = m; bus.sel = s;
        while (!bus.in_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.in_ready) chk(1'b0, "send_timeout", 8'(bus.in_ready), 8'd1);
        else q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        bus.in_valid = 1'b0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(q.size() == 0, "drain", 8'(q.size()), 8'd0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 bus.out_ready = v;
        @(negedge clk);
    endtask

    // Scoreboard and stall monitor
    bit         held_v = 1'b0;
    logic [7:0] held_out;
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                chk(bus.in_ready == 1'b0, "in_ready_stall", 8'(bus.in_ready), 8'd0);
                if (held_v) chk(bus.out == held_out, "hold_out", bus.out, held_out);
                held_v   = 1'b1;
                held_out = bus.out;
            end else begin
                held_v = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_word", bus.out, 8'h00);
                end else begin
                    e = q.pop_front();
                    chk(bus.out == e, "out", bus.out, e);
                    chk(bus.out_zero == (e == 8'h00), "out_zero", 8'(bus.out_zero), 8'(e == 8'h00));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'hA5, 1'b0, 2'b01, 3'd3, 8'hF4};
        tbl[1]  = '{8'hA5, 1'b1, 2'b00, 3'd5, 8'hA0};
        tbl[2]  = '{8'hA5, 1'b1, 2'b10, 3'd6, 8'h69};
        tbl[3]  = '{8'hA5, 1'b0, 2'b10, 3'd1, 8'hD2};
        tbl[4]  = '{8'hA5, 1'b0, 2'b11, 3'd2, 8'h29};
        tbl[5]  = '{8'h3C, 1'b1, 2'b01, 3'd0, 8'h3C};
        tbl[6]  = '{8'h81, 1'b0, 2'b10, 3'd0, 8'h81};
        tbl[7]  = '{8'h81, 1'b1, 2'b01, 3'd1, 8'h02};
        tbl[8]  = '{8'h7F, 1'b0, 2'b01, 3'd7, 8'h00};
        tbl[9]  = '{8'h80, 1'b0, 2'b01, 3'd7, 8'hFF};
        tbl[10] = '{8'h01, 1'b1, 2'b00, 3'd7, 8'h80};
        tbl[11] = '{8'h80, 1'b0, 2'b00, 3'd7, 8'h01};
        tbl[12] = '{8'h80, 1'b1, 2'b10, 3'd1, 8'h01};
        tbl[13] = '{8'h5A, 1'b1, 2'b11, 3'd3, 8'hD0};

        // Reset with a word already presented
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.data = 8'hA5; bus.left = 1'b0; bus.mode = 2'b00; bus.sel = 3'd1;
        repeat (3) @(negedge clk);
        chk(bus.out_valid == 1'b0, "rst_out_valid", 8'(bus.out_valid), 8'd0);
        chk(bus.out == 8'h00, "rst_out", bus.out, 8'h00);
        chk(bus.out_zero == 1'b1, "rst_out_zero", 8'(bus.out_zero), 8'd1);
        chk(bus.in_ready == 1'b1, "rst_in_ready", 8'(bus.in_ready), 8'd1);
        rst_n = 1'b1;
        send(8'hA5, 1'b0, 2'b00, 3'd1, 8'h52);
        drain();

        // Latency of a single isolated word
        begin
            int cnt = 0;
            bus.in_valid = 1'b1; bus.data = 8'h0F; bus.left = 1'b1; bus.mode = 2'b00; bus.sel = 3'd2;
            q.push_back(8'h3C);
            @(negedge clk);
            bus.in_valid = 1'b0;
            cnt = 1;
            while (!bus.out_valid && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            chk(cnt == LAT, "latency", 8'(cnt), 8'(LAT));
            drain();
        end

        for (int i = 0; i < NV; i++)
            send(tbl[i].data, tbl[i].left, tbl[i].mode, tbl[i].sel, tbl[i].exp);
        drain();

        // Back-to-back stream must emerge on consecutive cycles
        fork
            begin
                int t = 0;
                int run = 0;
                while (!bus.out_valid && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                while (bus.out_valid && run < 20) begin
                    run++;
                    @(negedge clk);
                end
                chk(run == 8, "stream_run", 8'(run), 8'd8);
            end
            begin
                for (int i = 0; i < 8; i++)
                    send(8'hFF, 1'b0, 2'b00, 3'(i), ref_shift(8'hFF, 1'b0, 2'b00, i));
                bus.in_valid = 1'b0;
            end
        join
        drain();

        // Backpressure mid-stream
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    logic [7:0] d;
                    logic       l;
                    logic [1:0] m;
                    logic [2:0] s;
                    d = 8'($urandom); l = 1'($urandom); m = 2'($urandom); s = 3'(i);
                    send(d, l, m, s, ref_shift(d, l, m, int'(s)));
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #2 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #2 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset while stalled with the pipeline full
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.data = 8'(8'h11 * (i + 1)); bus.left = 1'b0; bus.mode = 2'b00; bus.sel = 3'd0;
            @(negedge clk);
        end
        chk(bus.out_valid == 1'b1, "fill_valid", 8'(bus.out_valid), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk(bus.out_valid == 1'b0, "arst_out_valid", 8'(bus.out_valid), 8'd0);
        chk(bus.out == 8'h00, "arst_out", bus.out, 8'h00);
        chk(bus.out_zero == 1'b1, "arst_out_zero", 8'(bus.out_zero), 8'd1);
        chk(bus.in_ready == 1'b1, "arst_in_ready", 8'(bus.in_ready), 8'd1);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            chk(seen == 0, "no_stale", 8'(seen), 8'd0);
        end

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic [7:0] d;
                    logic       l;
                    logic [1:0] m;
                    logic [2:0] s;
                    d = 8'($urandom); l = 1'($urandom); m = 2'($urandom); s = 3'($urandom);
                    send(d, l, m, s, ref_shift(d, l, m, int'(s)));
                    if ($urandom_range(0, 4) == 0) idle(1);
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (150) begin
                    @(posedge clk);
                    #2 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                #2 bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        drain();
        chk(q.size() == 0, "queue_empty", 8'(q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bishift_datarev_pipe.md
# bishift_datarev_pipe

Parametrised, pipelined successor to the 8-bit data-reversal bidirectional barrel shifter. It shifts or rotates a WIDTH-bit word left or right by 0..WIDTH-1 positions, with logical, arithmetic and rotate modes. Direction is handled by conditional bit reversal around a single right-shift network. A valid/ready handshake on both sides lets it sit in streaming datapaths behind the shift/ALU front end.

## Interface
- WIDTH, 8, data width; power of two, 4..64
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word/controls valid
- in_ready  output  1  block can accept this cycle
- data  input  WIDTH  operand
- left  input  1  1 = shift/rotate left, 0 = right
- mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
- sel  input  SHW  shift amount
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out  output  WIDTH  result
- out_zero  output  1  out == 0, registered alongside out

## Operation
- Pipeline stages:
  - S1 captures data, left, mode, sel and valid.
  - Combinational path: reverse if left -> log2(WIDTH) right-shift layers (amounts 1, 2, 4, ...) -> reverse if left.
  - S_out registers out, out_zero and out_valid.
- Fill bit:
  - data[WIDTH-1] when mode=01 and left=0.
  - 0 otherwise (arithmetic left equals logical left).
  - Rotate mode: bits shifted out wrap to the vacated end; no fill.
- sel=0 passes data unchanged in every mode and direction.
- Handshake:
  - Global advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv.
  - Transfer occurs on an edge where valid & ready are both high.
  - When adv=0, all stage registers hold, including payloads of empty stages.
  - Bubbles (valid=0 stages) propagate. Payload registers may update freely while their valid is 0.
  - A stall never drops, duplicates or reorders a word.
- Reset (asynchronous, any time including mid-stall):
  - All valid bits clear.
  - out = 0, out_zero = 1.
  - in_ready = 1 once reset is released; it is high during reset because out_valid=0.
  - In-flight words are discarded.
- mode=11 produces exactly the mode=00 result.

## Timing
- Input accepted at edge N -> out/out_valid/out_zero visible after edge N+1 (latency 2 register stages; 3 with macro, visible after edge N+2).
- Throughput: 1 word/cycle while out_ready=1.
- out and out_zero are stable while out_valid=1 and out_ready=0.
- Reset values: out_valid 0, out 0, out_zero 1, in_ready 1.
- No combinational path from data/sel/left/mode to out. in_ready depends combinationally on out_ready.

## Configuration
- BISHIFT_PIPE_MID_EN:
  - Defined: an extra register stage S2 after the first ceil(SHW/2) shift layers, covering the partially shifted word, fill bit, remaining sel bits, left and valid. Latency 3, same handshake rules, S2 is stall-held like the others.
  - Undefined: no S2, latency 2.
  - Results are bit-identical in both builds.

## Test plan
- Reset with in_valid=1 held, WIDTH=8: out_valid=0, out=0x00, out_zero=1 during reset; first word 0xA5, right, logical, sel=1 -> out=0x52 after latency.
- Mode sweep on data 0xA5:
  - arithmetic right sel=3 -> 0xF4
  - logical left sel=5 -> 0xA0
  - rotate left sel=6 -> 0x69
  - rotate right sel=1 -> 0xD2
  - mode=11 right sel=2 -> 0x29
- Back-to-back stream of 8 words, sel=0..7, logical right on 0xFF: outputs 0xFF, 0x7F, ..., 0x01 on consecutive cycles; last word 0xFF>>7 = 0x01, out_zero=0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream. in_ready falls once out_valid=1, out is held stable, and no word is lost or duplicated once released (scoreboard).
- Asynchronous reset asserted mid-stall with pipeline full: outputs go to reset values immediately without a clock edge; no stale word appears after release.
- WIDTH=32, both macro builds: random data/sel/left/mode compared against a reference model with identical results; latency 2 vs 3 checked.
